// File: rtl/ask_demod_ctrl_pkg.sv
// Shared state codes, sync defaults and helpers for the ASK demodulator controller.
package ask_demod_ctrl_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StAcq    = 3'd2;
  localparam logic [2:0] StHunt   = 3'd3;
  localparam logic [2:0] StLock   = 3'd4;

  localparam logic [15:0] DefSyncWord = 16'hEB90;
  localparam int unsigned SyncLen     = 16;

  // Append one received bit at the LSB; the oldest bit ends up at the MSB.
  function automatic logic [15:0] shift_in(input logic [15:0] sreg, input logic b);
    return {sreg[14:0], b};
  endfunction

endpackage

// File: rtl/ask_demod_ctrl_if.sv
// Payload byte stream: valid/ready byte handshake plus frame and overflow pulses.
interface ask_demod_ctrl_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_done;
  logic       overflow;

  modport master (output byte_data, output byte_valid, output frame_done, output overflow,
                  input byte_ready);
  modport slave  (input byte_data, input byte_valid, input frame_done, input overflow,
                  output byte_ready);
endinterface

// File: rtl/ask_thr_est.sv
// Min/max window tracker: derives the slicer threshold as the midpoint of the envelope swing.
module ask_thr_est #(
  parameter int unsigned DW       = 14,
  parameter int unsigned AcqLen   = 256,
  parameter int unsigned MinSwing = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 sample_en_i,
  input  logic signed [DW-1:0] sample_i,
  output logic                 done_o,
  output logic                 ok_o,
  output logic signed [DW-1:0] threshold_o
);
  localparam int unsigned CntW = $clog2(AcqLen);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic signed [DW-1:0] max_q, max_d, min_q, min_d, thr_q, thr_d;
  logic signed [DW:0]   swing, sum;
  logic                 first, last;

  // Track extremes over the window and evaluate the swing on its last strobe.
  always_comb begin
    first = (cnt_q == '0);
    last  = (cnt_q == CntW'(AcqLen - 1));
    max_d = max_q;
    min_d = min_q;
    cnt_d = cnt_q;
    thr_d = thr_q;
    if (sample_en_i) begin
      max_d = (first || sample_i > max_q) ? sample_i : max_q;
      min_d = (first || sample_i < min_q) ? sample_i : min_q;
      cnt_d = last ? '0 : cnt_q + CntW'(1);
    end
    if (clear_i) cnt_d = '0;
    swing  = (DW+1)'(max_d) - (DW+1)'(min_d);
    sum    = (DW+1)'(max_d) + (DW+1)'(min_d);
    done_o = sample_en_i && last && !clear_i;
    ok_o   = done_o && (swing >= $signed((DW+1)'(MinSwing)));
    // A weak window leaves the previous threshold in place.
    if (ok_o) thr_d = DW'(sum >>> 1);
  end

  // Window state and threshold register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      max_q <= '0;
      min_q <= '0;
      thr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      min_q <= min_d;
      thr_q <= thr_d;
    end
  end

  assign threshold_o = thr_q;

endmodule

// File: rtl/ask_demod_ctrl.sv
// ASK acquisition/framing controller: settle, threshold acquisition, sync hunt, byte delivery.
module ask_demod_ctrl
  import ask_demod_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 14,
  parameter int unsigned SettleLen  = 64,
  parameter int unsigned AcqLen     = 256,
  parameter int unsigned MinSwing   = 16,
  parameter logic [15:0] SyncWord   = DefSyncWord,
  parameter int unsigned HuntBits   = 4096,
  parameter int unsigned FrameBytes = 32,
  parameter int unsigned BitTo      = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable_i,
  input  logic                 sample_en_i,
  input  logic signed [DW-1:0] demod_data_i,
  input  logic                 bit_stb_i,
  input  logic                 bit_in_i,
  output logic signed [DW-1:0] threshold_o,
  output logic                 thr_valid_o,
  output logic [2:0]           state_o,
  output logic                 locked_o,
  output logic                 lock_lost_o,
  ask_demod_ctrl_if.master     byte_if
);
  localparam int unsigned SetW  = $clog2(SettleLen);
  localparam int unsigned HuntW = $clog2(HuntBits);
  localparam int unsigned ByteW = $clog2(FrameBytes);
  localparam int unsigned ToW   = $clog2(BitTo);

  logic [2:0]       state_q, state_d;
  logic [SetW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [HuntW-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [15:0]      sreg_q, sreg_d, sreg_n;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             thr_valid_q, thr_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;
  logic             lock_lost_q, lock_lost_d;
  logic             in_acq, hunt_or_lock, timeout, acq_done, acq_ok;

  assign in_acq       = (state_q == StAcq);
  assign hunt_or_lock = (state_q == StHunt) || (state_q == StLock);

  ask_thr_est #(
    .DW       (DW),
    .AcqLen   (AcqLen),
    .MinSwing (MinSwing)
  ) u_thr_est (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (!in_acq),
    .sample_en_i (sample_en_i && in_acq),
    .sample_i    (demod_data_i),
    .done_o      (acq_done),
    .ok_o        (acq_ok),
    .threshold_o (threshold_o)
  );

  // Next-state logic for the acquisition FSM, sync hunt and byte assembly.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    hunt_cnt_d   = hunt_cnt_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    thr_valid_d  = thr_valid_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
    lock_lost_d  = 1'b0;
    sreg_n       = shift_in(sreg_q, bit_in_i);
    // A strobe on the expiry cycle still counts as activity.
    timeout      = hunt_or_lock && !bit_stb_i && (to_cnt_q == ToW'(BitTo - 1));
    to_cnt_d     = (hunt_or_lock && !bit_stb_i) ? to_cnt_q + ToW'(1) : '0;

    if (byte_valid_q && byte_if.byte_ready) byte_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
        end
      end
      StSettle: begin
        if (sample_en_i) begin
          if (settle_cnt_q == SetW'(SettleLen - 1)) begin
            state_d      = StAcq;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SetW'(1);
          end
        end
      end
      StAcq: begin
        // A failed window simply restarts inside the estimator.
        if (acq_done && acq_ok) begin
          state_d     = StHunt;
          thr_valid_d = 1'b1;
          hunt_cnt_d  = '0;
          sreg_d      = '0;
        end
      end
      StHunt: begin
        if (timeout) begin
          state_d     = StAcq;
          lock_lost_d = 1'b1;
        end else if (bit_stb_i) begin
          sreg_d     = sreg_n;
          hunt_cnt_d = hunt_cnt_q + HuntW'(1);
          if (sreg_n == SyncWord && hunt_cnt_q >= HuntW'(SyncLen - 1)) begin
            state_d    = StLock;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end else if (hunt_cnt_q == HuntW'(HuntBits - 1)) begin
            state_d = StAcq;
          end
        end
      end
      StLock: begin
        if (timeout) begin
          state_d     = StAcq;
          lock_lost_d = 1'b1;
          bit_cnt_d   = '0;
        end else if (bit_stb_i) begin
          sreg_d    = sreg_n;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Loading on the acceptance cycle is allowed; otherwise the new byte is lost.
            if (!byte_valid_q || byte_if.byte_ready) begin
              byte_data_d  = sreg_n[7:0];
              byte_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            byte_cnt_d = byte_cnt_q + ByteW'(1);
            if (byte_cnt_q == ByteW'(FrameBytes - 1)) begin
              frame_done_d = 1'b1;
              state_d      = StHunt;
              hunt_cnt_d   = '0;
              byte_cnt_d   = '0;
              bit_cnt_d    = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable_i) begin
      state_d      = StIdle;
      settle_cnt_d = '0;
      hunt_cnt_d   = '0;
      bit_cnt_d    = '0;
      byte_cnt_d   = '0;
      to_cnt_d     = '0;
      thr_valid_d  = 1'b0;
      byte_valid_d = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
      lock_lost_d  = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      hunt_cnt_q   <= '0;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
      thr_valid_q  <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      hunt_cnt_q   <= hunt_cnt_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      to_cnt_q     <= to_cnt_d;
      thr_valid_q  <= thr_valid_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign thr_valid_o        = thr_valid_q;
  assign state_o            = state_q;
  assign locked_o           = (state_q == StLock);
  assign lock_lost_o        = lock_lost_q;
  assign byte_if.byte_data  = byte_data_q;
  assign byte_if.byte_valid = byte_valid_q;
  assign byte_if.frame_done = frame_done_q;
  assign byte_if.overflow   = overflow_q;

endmodule

// File: tb/tb_ask_demod_ctrl.sv
// Directed bench for ask_demod_ctrl: acquisition, sync, framing, overflow, timeout, reset.
module tb_ask_demod_ctrl;
  localparam int unsigned DW = 14;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 sample_en = 1'b0;
  logic signed [DW-1:0] demod_data = '0;
  logic                 bit_stb = 1'b0;
  logic                 bit_in = 1'b0;
  logic signed [DW-1:0] threshold;
  logic                 thr_valid;
  logic [2:0]           state;
  logic                 locked;
  logic                 lock_lost;
  int                   n_chk = 0;
  int                   n_bad = 0;

  ask_demod_ctrl_if bif ();

  ask_demod_ctrl #(.DW(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable_i     (enable),
    .sample_en_i  (sample_en),
    .demod_data_i (demod_data),
    .bit_stb_i    (bit_stb),
    .bit_in_i     (bit_in),
    .threshold_o  (threshold),
    .thr_valid_o  (thr_valid),
    .state_o      (state),
    .locked_o     (locked),
    .lock_lost_o  (lock_lost),
    .byte_if      (bif)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic sample(input int v);
    demod_data = DW'(v);
    sample_en  = 1'b1;
    tick(1);
    sample_en  = 1'b0;
  endtask

  // n strobes every 4 clocks, alternating hi/lo starting with hi.
  task automatic samples(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      sample((i % 2 == 0) ? hi : lo);
      tick(3);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_stb = 1'b1;
    tick(1);
    bit_stb = 1'b0;
  endtask

  // n bits MSB-first; returns right after the last strobe edge.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i]);
      if (i != 0) tick(3);
    end
  endtask

  initial begin
    bif.byte_ready = 1'b0;
    tick(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_thr", 32'(threshold), 32'd0);
    check("rst_thr_valid", 32'(thr_valid), 32'd0);
    check("rst_byte_valid", 32'(bif.byte_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);

    reset_n = 1'b1;
    enable  = 1'b1;
    tick(1);
    check("settle_state", 32'(state), 32'd1);

    // Weak signal: swing 10 never qualifies.
    samples(64 + 512, 55, 45);
    check("flat_state", 32'(state), 32'd2);
    check("flat_thr_valid", 32'(thr_valid), 32'd0);
    check("flat_thr", 32'(threshold), 32'd0);

    enable = 1'b0;
    tick(1);
    check("disable_state", 32'(state), 32'd0);
    enable = 1'b1;
    tick(1);

    // Square envelope 250 / -150: midpoint 50.
    samples(64 + 255, 250, -150);
    check("acq_pre_state", 32'(state), 32'd2);
    check("acq_pre_valid", 32'(thr_valid), 32'd0);
    sample(-150);
    check("acq_state", 32'(state), 32'd3);
    check("acq_thr", 32'(threshold), 32'd50);
    check("acq_thr_valid", 32'(thr_valid), 32'd1);
    tick(3);

    // Sync then a full frame 00..1F.
    send_bits(16'hEB90, 16);
    check("sync_state", 32'(state), 32'd4);
    check("sync_locked", 32'(locked), 32'd1);
    tick(3);
    bif.byte_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      send_bits(16'(k), 8);
      check("frm_valid", 32'(bif.byte_valid), 32'd1);
      check("frm_data", 32'(bif.byte_data), 32'(k));
      if (k == 30) check("frm_done_early", 32'(bif.frame_done), 32'd0);
      if (k == 31) begin
        check("frm_done", 32'(bif.frame_done), 32'd1);
        check("frm_state", 32'(state), 32'd3);
      end
      tick(3);
    end

    // Consumer stalls across two bytes.
    bif.byte_ready = 1'b0;
    send_bits(16'hEB90, 16);
    check("ov_sync_state", 32'(state), 32'd4);
    tick(3);
    send_bits(16'h0000, 8);
    check("ov_valid0", 32'(bif.byte_valid), 32'd1);
    check("ov_data0", 32'(bif.byte_data), 32'h00);
    tick(3);
    send_bits(16'h0001, 8);
    check("ov_pulse", 32'(bif.overflow), 32'd1);
    check("ov_hold_data", 32'(bif.byte_data), 32'h00);
    check("ov_hold_valid", 32'(bif.byte_valid), 32'd1);
    tick(1);
    check("ov_pulse_end", 32'(bif.overflow), 32'd0);
    tick(2);
    bif.byte_ready = 1'b1;
    tick(1);
    check("ov_accept", 32'(bif.byte_valid), 32'd0);

    // Bit timeout boundary: strobe on cycle 1024 rescues, silence does not.
    send_bit(1'b1);
    tick(1023);
    check("to_edge_state", 32'(state), 32'd4);
    send_bit(1'b0);
    check("to_rescue_lost", 32'(lock_lost), 32'd0);
    check("to_rescue_state", 32'(state), 32'd4);
    tick(1023);
    check("to_pre_lost", 32'(lock_lost), 32'd0);
    tick(1);
    check("to_lost", 32'(lock_lost), 32'd1);
    check("to_state", 32'(state), 32'd2);
    tick(1);
    check("to_lost_end", 32'(lock_lost), 32'd0);

    // Re-acquire, lock, leave a byte pending, then reset asynchronously.
    samples(256, 250, -150);
    check("reacq_state", 32'(state), 32'd3);
    bif.byte_ready = 1'b0;
    tick(3);
    send_bits(16'hEB90, 16);
    tick(3);
    send_bits(16'h00A5, 8);
    check("pend_valid", 32'(bif.byte_valid), 32'd1);
    check("pend_data", 32'(bif.byte_data), 32'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_valid", 32'(bif.byte_valid), 32'd0);
    check("arst_data", 32'(bif.byte_data), 32'd0);
    check("arst_thr", 32'(threshold), 32'd0);
    check("arst_thr_valid", 32'(thr_valid), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
